// File: rtl/enemy_formation.sv
// enemy_formation: row of NUM_SHIPS enemies marching as one block with edge bounce/drop,
// laser kills, saturating score and clear/gameover states. `ENEMY_SPEEDUP_EN doubles the step late in the wave.

module enemy_ship_lane #(
   parameter int IDX       = 0,
   parameter int SHIP_W    = 32,
   parameter int SHIP_H    = 32,
   parameter int X_START   = 50,
   parameter int X_SPACING = 50,
   parameter int X_MAX     = 639
) (
   input  logic signed [10:0] x_off,
   input  logic        [9:0]  y,
   input  logic signed [12:0] step,
   input  logic        [9:0]  laser_x,
   input  logic        [9:0]  laser_y,
   input  logic        [9:0]  draw_x,
   input  logic        [9:0]  draw_y,
   output logic               laser_in,
   output logic               pix_in,
   output logic               edge_r,
   output logic               edge_l,
   output logic        [4:0]  spr_x,
   output logic        [4:0]  spr_y
);
   localparam logic signed [12:0] BASE = 13'(X_START + IDX*X_SPACING);
   localparam logic signed [12:0] W    = 13'(SHIP_W);
   localparam logic signed [12:0] XM   = 13'(X_MAX);

   // 13-bit signed x keeps a ship sliding past column 0 from wrapping
   logic signed [12:0] xi, lx, dx;
   logic        [10:0] yy, ly, dy;

   assign xi = BASE + {{2{x_off[10]}}, x_off};
   assign lx = {3'b000, laser_x};
   assign dx = {3'b000, draw_x};
   assign yy = {1'b0, y};
   assign ly = {1'b0, laser_y};
   assign dy = {1'b0, draw_y};

   assign laser_in = (lx >= xi) && (lx < xi + W) && (ly >= yy) && (ly < yy + 11'(SHIP_H));
   assign pix_in   = (dx >= xi) && (dx < xi + W) && (dy >= yy) && (dy < yy + 11'(SHIP_H));
   assign edge_r   = (xi + W - 13'sd1 + step) > XM;
   assign edge_l   = (xi - step) < 13'sd0;
   assign spr_x    = 5'(dx - xi);
   assign spr_y    = 5'(draw_y - y);
endmodule

module enemy_formation #(
   parameter int NUM_SHIPS = 6,
   parameter int SHIP_W    = 32,
   parameter int SHIP_H    = 32,
   parameter int X_START   = 50,
   parameter int X_SPACING = 50,
   parameter int Y_START   = 40,
   parameter int STEP_X    = 1,
   parameter int DROP_Y    = 16,
   parameter int X_MAX     = 639,
   parameter int Y_LIMIT   = 416,
   parameter int SCORE_W   = 8
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 frame_clk,
   input  logic                 play,
   input  logic                 done,
   input  logic [9:0]           DrawX,
   input  logic [9:0]           DrawY,
   input  logic [9:0]           laser_x,
   input  logic [9:0]           laser_y,
   input  logic                 laser_active,
   output logic                 laser_hit,
   output logic [NUM_SHIPS-1:0] alive,
   output logic                 is_enemy_ship,
   output logic [3:0]           ship_idx,
   output logic [4:0]           spr_x,
   output logic [4:0]           spr_y,
   output logic [SCORE_W-1:0]   score,
   output logic                 wave_clear,
   output logic                 gameover
);
   typedef enum logic [1:0] {IDLE, MARCH, CLEAR, OVER} state_t;

   state_t               state, state_nxt;
   logic signed [10:0]   x_off, x_off_nxt;
   logic [9:0]           y, y_nxt;
   logic                 dir_left, dir_left_nxt;
   logic [NUM_SHIPS-1:0] alive_nxt;
   logic [SCORE_W-1:0]   score_nxt;
   logic                 hit_nxt;
   logic                 fc_q1, fc_q2, tick;

   logic [NUM_SHIPS-1:0]      laser_in_v, pix_in_v, edge_r_v, edge_l_v;
   logic [NUM_SHIPS-1:0][4:0] sx_v, sy_v;
   logic [NUM_SHIPS-1:0]      hit_v, kill_v, alive_post;
   logic signed [12:0]        step;
   logic                      bounce, reached;

   assign tick = fc_q1 & ~fc_q2;

   for (genvar i = 0; i < NUM_SHIPS; i++) begin : g_lane
      enemy_ship_lane #(
         .IDX(i), .SHIP_W(SHIP_W), .SHIP_H(SHIP_H),
         .X_START(X_START), .X_SPACING(X_SPACING), .X_MAX(X_MAX)
      ) u_lane (
         .x_off(x_off), .y(y), .step(step),
         .laser_x(laser_x), .laser_y(laser_y), .draw_x(DrawX), .draw_y(DrawY),
         .laser_in(laser_in_v[i]), .pix_in(pix_in_v[i]),
         .edge_r(edge_r_v[i]), .edge_l(edge_l_v[i]),
         .spr_x(sx_v[i]), .spr_y(sy_v[i])
      );
   end

   // lowest hit ship isolated with x & -x; only alive ships can absorb the laser
   assign hit_v      = laser_in_v & alive & {NUM_SHIPS{laser_active}};
   assign kill_v     = hit_v & (~hit_v + NUM_SHIPS'(1));
   assign alive_post = alive & ~kill_v;

`ifdef ENEMY_SPEEDUP_EN
   assign step = ($countones(alive_post) <= NUM_SHIPS/2) ? 13'(2*STEP_X) : 13'(STEP_X);
`else
   assign step = 13'(STEP_X);
`endif

   // any surviving ship over the edge is equivalent to the outermost survivor being over it
   assign bounce  = dir_left ? |(edge_l_v & alive_post) : |(edge_r_v & alive_post);
   assign reached = ({1'b0, y} + 11'(SHIP_H)) >= 11'(Y_LIMIT);

   always_comb begin
      state_nxt    = state;
      x_off_nxt    = x_off;
      y_nxt        = y;
      dir_left_nxt = dir_left;
      alive_nxt    = alive;
      score_nxt    = score;
      hit_nxt      = 1'b0;
      if (done) begin
         state_nxt    = IDLE;
         x_off_nxt    = '0;
         y_nxt        = 10'(Y_START);
         dir_left_nxt = 1'b0;
         alive_nxt    = '1;
         score_nxt    = '0;
      end else begin
         case (state)
            IDLE: if (play) state_nxt = MARCH;
            MARCH: begin
               if (alive == '0)
                  state_nxt = CLEAR;
               else if (reached)
                  state_nxt = OVER;
               else if (play && tick) begin
                  alive_nxt = alive_post;
                  if (|hit_v) begin
                     hit_nxt = 1'b1;
                     if (score != '1) score_nxt = score + SCORE_W'(1);
                  end
                  if (bounce) begin
                     dir_left_nxt = ~dir_left;
                     y_nxt        = y + 10'(DROP_Y);
                  end else if (dir_left)
                     x_off_nxt = x_off - step[10:0];
                  else
                     x_off_nxt = x_off + step[10:0];
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         x_off     <= '0;
         y         <= 10'(Y_START);
         dir_left  <= 1'b0;
         alive     <= '1;
         score     <= '0;
         laser_hit <= 1'b0;
         fc_q1     <= 1'b0;
         fc_q2     <= 1'b0;
      end else begin
         state     <= state_nxt;
         x_off     <= x_off_nxt;
         y         <= y_nxt;
         dir_left  <= dir_left_nxt;
         alive     <= alive_nxt;
         score     <= score_nxt;
         laser_hit <= hit_nxt;
         fc_q1     <= done ? 1'b0 : frame_clk;
         fc_q2     <= done ? 1'b0 : fc_q1;
      end
   end

   assign wave_clear = (state == CLEAR);
   assign gameover   = (state == OVER);

   // descending scan so the lowest covering ship is the one left selected
   always_comb begin
      is_enemy_ship = 1'b0;
      ship_idx      = '0;
      spr_x         = '0;
      spr_y         = '0;
      for (int i = NUM_SHIPS-1; i >= 0; i--) begin
         if (alive[i] && pix_in_v[i]) begin
            is_enemy_ship = 1'b1;
            ship_idx      = 4'(i);
            spr_x         = sx_v[i];
            spr_y         = sy_v[i];
         end
      end
   end
endmodule

// File: tb/tb_enemy_formation.sv
// Bench for enemy_formation: reference model of the formation rules, randomized laser/play
// traffic, edge bounce, wave clear, gameover and done restore.
module tb_enemy_formation;
   localparam int N = 6;
   localparam int STEP = 1;

   logic Clk = 1'b0;
   logic Reset, frame_clk, play, done, laser_active;
   logic [9:0] DrawX, DrawY, laser_x, laser_y;
   logic laser_hit, is_enemy_ship, wave_clear, gameover;
   logic [N-1:0] alive;
   logic [3:0] ship_idx;
   logic [4:0] spr_x, spr_y;
   logic [7:0] score;

   int n_cmp = 0, n_bad = 0;

   // reference model: 0 idle, 1 march, 2 clear, 3 over
   int m_xoff, m_y, m_left, m_score, m_st;
   logic [N-1:0] m_alive;

   enemy_formation dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .play(play), .done(done),
      .DrawX(DrawX), .DrawY(DrawY), .laser_x(laser_x), .laser_y(laser_y),
      .laser_active(laser_active), .laser_hit(laser_hit), .alive(alive),
      .is_enemy_ship(is_enemy_ship), .ship_idx(ship_idx), .spr_x(spr_x), .spr_y(spr_y),
      .score(score), .wave_clear(wave_clear), .gameover(gameover)
   );

   always #10 Clk = ~Clk;

   function automatic int mx(input int i);
      return 50 + i*50 + m_xoff;
   endfunction

   function automatic int lowest_alive();
      for (int i = 0; i < N; i++) if (m_alive[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_xoff = 0; m_y = 40; m_left = 0; m_score = 0; m_st = 0; m_alive = '1;
   endtask

   task automatic model_tick(output int hit);
      int step, lo, hi;
      hit = 0;
      if (m_st == 0 && play) m_st = 1;
      if (m_st == 1 && play) begin
         if (laser_active)
            for (int i = 0; i < N; i++)
               if (hit == 0 && m_alive[i] && int'(laser_x) >= mx(i) && int'(laser_x) < mx(i)+32 &&
                   int'(laser_y) >= m_y && int'(laser_y) < m_y+32) begin
                  m_alive[i] = 1'b0; hit = 1;
                  if (m_score < 255) m_score++;
               end
         step = STEP;
`ifdef ENEMY_SPEEDUP_EN
         if ($countones(m_alive) <= N/2) step = 2*STEP;
`endif
         lo = 10000; hi = -10000;
         for (int i = 0; i < N; i++)
            if (m_alive[i]) begin
               if (mx(i) < lo) lo = mx(i);
               if (mx(i) > hi) hi = mx(i);
            end
         if (m_alive != 0 && ((!m_left && hi+31+step > 639) || (m_left && lo-step < 0))) begin
            m_left = !m_left; m_y += 16;
         end else
            m_xoff += m_left ? -step : step;
      end
      if (m_st == 1) begin
         if (m_alive == 0) m_st = 2;
         else if (m_y + 32 >= 416) m_st = 3;
      end
   endtask

   // one frame strobe; counts laser_hit cycles seen around it
   task automatic do_tick(output int got, output int exp_hit);
      got = 0;
      model_tick(exp_hit);
      @(negedge Clk) frame_clk = 1'b1;
      repeat (3) begin @(negedge Clk); got += int'(laser_hit); end
      frame_clk = 1'b0;
      repeat (3) begin @(negedge Clk); got += int'(laser_hit); end
   endtask

   task automatic probe(input int px, input int py);
      DrawX = 10'(px); DrawY = 10'(py); #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; frame_clk = 0; play = 0; done = 0; laser_active = 0;
      laser_x = 0; laser_y = 0; DrawX = 0; DrawY = 0;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      model_reset();
      @(negedge Clk);
      probe(50, 40);
      n_cmp++; if (alive !== 6'b111111) begin n_bad++; $display("FAIL reset_alive got %b exp 111111", alive); end
      n_cmp++; if (score !== 8'd0) begin n_bad++; $display("FAIL reset_score got %0d exp 0", score); end
      n_cmp++; if ({laser_hit, wave_clear, gameover} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b exp 000", {laser_hit, wave_clear, gameover}); end
      n_cmp++; if ({is_enemy_ship, ship_idx, spr_x, spr_y} !== {1'b1, 4'd0, 5'd0, 5'd0}) begin n_bad++; $display("FAIL reset_pix50 got %b/%0d/%0d/%0d exp 1/0/0/0", is_enemy_ship, ship_idx, spr_x, spr_y); end
      probe(49, 40);
      n_cmp++; if ({is_enemy_ship, ship_idx, spr_x, spr_y} !== 15'd0) begin n_bad++; $display("FAIL reset_pix49 got %b/%0d/%0d/%0d exp all 0", is_enemy_ship, ship_idx, spr_x, spr_y); end
   endtask

   task automatic test_march();
      int got, eh;
      play = 1'b1;
      repeat (10) begin
         do_tick(got, eh);
         n_cmp++; if (got != eh) begin n_bad++; $display("FAIL march_hit got %0d exp %0d", got, eh); end
      end
      probe(mx(0), m_y);
      n_cmp++; if ({is_enemy_ship, ship_idx, spr_x} !== {1'b1, 4'd0, 5'd0}) begin n_bad++; $display("FAIL march_ship0 got %b/%0d/%0d exp 1/0/0 at x %0d", is_enemy_ship, ship_idx, spr_x, mx(0)); end
      probe(mx(0)-1, m_y);
      n_cmp++; if (is_enemy_ship !== 1'b0) begin n_bad++; $display("FAIL march_gap got %b exp 0", is_enemy_ship); end
      probe(mx(5)+31, m_y+31);
      n_cmp++; if ({is_enemy_ship, ship_idx, spr_x, spr_y} !== {1'b1, 4'd5, 5'd31, 5'd31}) begin n_bad++; $display("FAIL march_ship5 got %b/%0d/%0d/%0d exp 1/5/31/31", is_enemy_ship, ship_idx, spr_x, spr_y); end
   endtask

   task automatic test_laser();
      int got, eh;
      laser_x = 10'd66; laser_y = 10'd50; laser_active = 1'b1;
      do_tick(got, eh);
      laser_active = 1'b0;
      n_cmp++; if (got != eh) begin n_bad++; $display("FAIL laser_hit_cycles got %0d exp %0d", got, eh); end
      n_cmp++; if (alive !== m_alive) begin n_bad++; $display("FAIL laser_alive got %b exp %b", alive, m_alive); end
      n_cmp++; if (int'(score) != m_score) begin n_bad++; $display("FAIL laser_score got %0d exp %0d", score, m_score); end
      probe(mx(0)+5, m_y+5);
      n_cmp++; if (is_enemy_ship !== 1'b0) begin n_bad++; $display("FAIL laser_dead_drawn got %b exp 0", is_enemy_ship); end
   endtask

   task automatic test_bounce();
      int got, eh, guard;
      guard = 0;
      while (m_xoff < 308 && guard < 400) begin do_tick(got, eh); guard++; end
      n_cmp++; if (guard >= 400) begin n_bad++; $display("FAIL bounce_timeout got %0d exp <400", guard); end
      probe(639, m_y);
      n_cmp++; if ({is_enemy_ship, ship_idx, spr_x} !== {1'b1, 4'd5, 5'd31}) begin n_bad++; $display("FAIL bounce_edge got %b/%0d/%0d exp 1/5/31", is_enemy_ship, ship_idx, spr_x); end
      do_tick(got, eh);
      probe(mx(5), m_y);
      n_cmp++; if ({is_enemy_ship, ship_idx, spr_x, spr_y} !== {1'b1, 4'd5, 5'd0, 5'd0}) begin n_bad++; $display("FAIL bounce_drop got %b/%0d/%0d/%0d exp 1/5/0/0 y %0d", is_enemy_ship, ship_idx, spr_x, spr_y, m_y); end
      probe(mx(5), m_y-1);
      n_cmp++; if (is_enemy_ship !== 1'b0) begin n_bad++; $display("FAIL bounce_above got %b exp 0", is_enemy_ship); end
      do_tick(got, eh);
      probe(639, m_y);
      n_cmp++; if (is_enemy_ship !== 1'b0) begin n_bad++; $display("FAIL bounce_left got %b exp 0", is_enemy_ship); end
      probe(mx(5)+31, m_y);
      n_cmp++; if ({is_enemy_ship, spr_x} !== {1'b1, 5'd31}) begin n_bad++; $display("FAIL bounce_left_edge got %b/%0d exp 1/31", is_enemy_ship, spr_x); end
   endtask

   task automatic test_random();
      int got, eh, k, lo, dx, dy;
      repeat (80) begin
         play = ($urandom_range(0, 9) != 0);
         laser_active = ($urandom_range(0, 3) == 0);
         k = $urandom_range(0, N-1);
         laser_x = 10'(mx(k) + $urandom_range(0, 40));
         laser_y = 10'(m_y + $urandom_range(0, 40));
         do_tick(got, eh);
         n_cmp++; if (got != eh) begin n_bad++; $display("FAIL rand_hit got %0d exp %0d", got, eh); end
         n_cmp++; if (alive !== m_alive || int'(score) != m_score) begin n_bad++; $display("FAIL rand_alive_score got %b/%0d exp %b/%0d", alive, score, m_alive, m_score); end
         lo = lowest_alive();
         if (lo >= 0) begin
            dx = $urandom_range(0, 31); dy = $urandom_range(0, 31);
            probe(mx(lo)+dx, m_y+dy);
            n_cmp++; if ({is_enemy_ship, ship_idx, spr_x, spr_y} !== {1'b1, 4'(lo), 5'(dx), 5'(dy)}) begin n_bad++; $display("FAIL rand_pix got %b/%0d/%0d/%0d exp 1/%0d/%0d/%0d", is_enemy_ship, ship_idx, spr_x, spr_y, lo, dx, dy); end
         end
      end
      play = 1'b1; laser_active = 1'b0;
   endtask

   task automatic test_clear();
      int got, eh, guard, lo;
      guard = 0;
      laser_active = 1'b1;
      while (m_alive != 0 && guard < 20) begin
         lo = lowest_alive();
         laser_x = 10'(mx(lo)+16); laser_y = 10'(m_y+16);
         do_tick(got, eh);
         n_cmp++; if (got != 1 || eh != 1) begin n_bad++; $display("FAIL clear_kill got %0d exp 1 (model %0d)", got, eh); end
         guard++;
      end
      laser_active = 1'b0;
      n_cmp++; if ({wave_clear, gameover} !== {m_st == 2, m_st == 3}) begin n_bad++; $display("FAIL clear_flags got %b%b exp %b%b", wave_clear, gameover, m_st == 2, m_st == 3); end
      n_cmp++; if (int'(score) != m_score || alive !== '0) begin n_bad++; $display("FAIL clear_score got %0d/%b exp %0d/0", score, alive, m_score); end
      repeat (3) do_tick(got, eh);
      probe(mx(0), m_y);
      n_cmp++; if ({wave_clear, is_enemy_ship, laser_hit} !== 3'b100) begin n_bad++; $display("FAIL clear_hold got %b exp 100", {wave_clear, is_enemy_ship, laser_hit}); end
   endtask

   task automatic test_done();
      play = 1'b0;
      @(negedge Clk) done = 1'b1;
      @(negedge Clk) done = 1'b0;
      model_reset();
      probe(50, 40);
      n_cmp++; if (alive !== 6'b111111 || score !== 8'd0) begin n_bad++; $display("FAIL done_state got %b/%0d exp 111111/0", alive, score); end
      n_cmp++; if ({wave_clear, gameover, laser_hit} !== 3'b000) begin n_bad++; $display("FAIL done_flags got %b exp 000", {wave_clear, gameover, laser_hit}); end
      n_cmp++; if ({is_enemy_ship, ship_idx, spr_x} !== {1'b1, 4'd0, 5'd0}) begin n_bad++; $display("FAIL done_pos got %b/%0d/%0d exp 1/0/0", is_enemy_ship, ship_idx, spr_x); end
   endtask

   task automatic test_gameover();
      int got, eh, guard, ox, oy;
      play = 1'b1; laser_active = 1'b0; guard = 0;
      while (m_st != 3 && guard < 8000) begin do_tick(got, eh); guard++; end
      n_cmp++; if (guard >= 8000) begin n_bad++; $display("FAIL over_timeout got %0d exp <8000", guard); end
      n_cmp++; if ({gameover, wave_clear} !== 2'b10) begin n_bad++; $display("FAIL over_flags got %b exp 10", {gameover, wave_clear}); end
      ox = m_xoff; oy = m_y;
      repeat (2) do_tick(got, eh);
      probe(50+ox, oy);
      n_cmp++; if ({is_enemy_ship, ship_idx, spr_x, spr_y} !== {1'b1, 4'd0, 5'd0, 5'd0}) begin n_bad++; $display("FAIL over_frozen got %b/%0d/%0d/%0d exp 1/0/0/0", is_enemy_ship, ship_idx, spr_x, spr_y); end
      test_done();
   endtask

   task automatic test_speedup();
      int got, eh;
      play = 1'b1;
      for (int k = 0; k < 3; k++) begin
         laser_active = 1'b1;
         laser_x = 10'(mx(k)+10); laser_y = 10'(m_y+10);
         do_tick(got, eh);
         n_cmp++; if (got != eh || alive !== m_alive) begin n_bad++; $display("FAIL speed_kill got %0d/%b exp %0d/%b", got, alive, eh, m_alive); end
      end
      laser_active = 1'b0;
      repeat (2) begin
         do_tick(got, eh);
         probe(mx(3), m_y);
         n_cmp++; if ({is_enemy_ship, ship_idx, spr_x} !== {1'b1, 4'd3, 5'd0}) begin n_bad++; $display("FAIL speed_pos got %b/%0d/%0d exp 1/3/0 at x %0d", is_enemy_ship, ship_idx, spr_x, mx(3)); end
         probe(mx(3)-1, m_y);
         n_cmp++; if (is_enemy_ship !== 1'b0) begin n_bad++; $display("FAIL speed_left got %b exp 0", is_enemy_ship); end
      end
      probe(mx(2)+5, m_y+5);
      n_cmp++; if (is_enemy_ship !== 1'b0) begin n_bad++; $display("FAIL speed_dead got %b exp 0", is_enemy_ship); end
   endtask

   initial begin
      test_reset();
      test_march();
      test_laser();
      test_bounce();
      test_random();
      test_clear();
      test_done();
      test_gameover();
      test_speedup();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
